// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: issue/sequencing controller for the multi-cycle FPU.
// Accepts one decoded F-type op at a time, counts its latency and pulses writeback.
// Also generates the decode-stage stall for a busy FPU and for RAW hazards
// against the pending FP destination.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   issue_valid         decode holds an F-type op (fpu_control/fp_regwrite/fp_dst/src_a/src_b)
//   use_valid, use_reg  non-FPU instruction in decode reads FP register use_reg
//   flush               decode-stage flush, blocks acceptance this cycle
//   fpu_start           one-cycle start pulse to the datapath (accept cycle)
//   fpu_op              latched op code held during execution
//   stall_d             freeze fetch/decode
//   wb_valid/wb_dst/wb_regwrite  one-cycle writeback strobe and its payload
//   busy                op in flight
//   illegal_op          pulse on an unsupported fpu_control
module fpu_seq_ctrl #(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned UN_LAT  = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issue_valid,
    input  logic [3:0] fpu_control,
    input  logic       fp_regwrite,
    input  logic [4:0] fp_dst,
    input  logic [4:0] src_a,
    input  logic [4:0] src_b,
    input  logic       use_valid,
    input  logic [4:0] use_reg,
    input  logic       flush,
    output logic       fpu_start,
    output logic [3:0] fpu_op,
    output logic       stall_d,
    output logic       wb_valid,
    output logic [4:0] wb_dst,
    output logic       wb_regwrite,
    output logic       busy,
    output logic       illegal_op
);

    localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int unsigned MAX_DU  = (DIV_LAT > UN_LAT) ? DIV_LAT : UN_LAT;
    localparam int unsigned MAX_LAT = (MAX_AM > MAX_DU) ? MAX_AM : MAX_DU;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q;
    logic [4:0]         dst_q;
    logic               rw_q;

    logic               legal;
    logic               in_exec;
    logic               pend_hit;
    logic               accept;
    logic [CNT_W-1:0]   lat;

    // Latency select for the op sitting in decode
    always_comb begin
        lat = CNT_W'(ADD_LAT);
        case (fpu_control)
            4'b0000, 4'b0001: lat = CNT_W'(ADD_LAT);
            4'b0010:          lat = CNT_W'(MUL_LAT);
            4'b0011:          lat = CNT_W'(DIV_LAT);
            4'b0100, 4'b0101: lat = CNT_W'(UN_LAT);
            default:          lat = CNT_W'(ADD_LAT);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Op latches, loaded only on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= 4'b0000;
            dst_q <= 5'd0;
            rw_q  <= 1'b0;
        end else if (accept) begin
            op_q  <= fpu_control;
            dst_q <= fp_dst;
            rw_q  <= fp_regwrite;
        end
    end

    // Next state, hazard detection and outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        legal       = (fpu_control <= 4'd5);
        in_exec     = (state_q == EXEC);
        // RAW only in EXEC: in DONE the register file writes before it is read
        pend_hit    = in_exec & rw_q &
                      ((issue_valid & legal & ((src_a == dst_q) | (src_b == dst_q))) |
                       (use_valid & (use_reg == dst_q)));
        // reset_n gates the input-driven outputs so reset forces them low at once
        accept      = reset_n & issue_valid & ~flush & legal & ~in_exec & ~pend_hit;
        fpu_start   = accept;
        stall_d     = reset_n & ~flush & ((issue_valid & legal & in_exec) | pend_hit);
        illegal_op  = reset_n & issue_valid & ~flush & ~legal;
        wb_valid    = (state_q == DONE);
        busy        = (state_q != IDLE);
        wb_regwrite = wb_valid & rw_q;
        wb_dst      = dst_q;
        fpu_op      = op_q;

        case (state_q)
            IDLE: state_d = IDLE;
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new accept (from IDLE or back-to-back from DONE) overrides the above
        if (accept) begin
            cnt_d   = lat - CNT_W'(1);
            state_d = (lat > CNT_W'(1)) ? EXEC : DONE;
        end
    end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Self-checking bench for fpu_seq_ctrl: directed scenarios followed by random
// stimulus, all checked against a timestamp-based model of the issue rules.
module tb_fpu_seq_ctrl;

    logic       clk;
    logic       reset_n;
    logic       iv;
    logic [3:0] ctrl;
    logic       rw;
    logic [4:0] dst;
    logic [4:0] sa;
    logic [4:0] sb;
    logic       uv;
    logic [4:0] ur;
    logic       fl;

    logic       fpu_start;
    logic [3:0] fpu_op;
    logic       stall_d;
    logic       wb_valid;
    logic [4:0] wb_dst;
    logic       wb_regwrite;
    logic       busy;
    logic       illegal_op;

    int total;
    int bad;

    // model: op in flight with its writeback cycle timestamp
    int cyc;
    bit inflight;
    int wb_at;
    int m_op;
    int m_dst;
    bit m_rw;

    // last observed outputs (sampled inside tick)
    logic       got_start, got_stall, got_wb, got_ill, got_busy;
    logic [4:0] got_wbdst;

    int nstall;

    fpu_seq_ctrl #(.ADD_LAT(2), .MUL_LAT(4), .DIV_LAT(10), .UN_LAT(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (iv),
        .fpu_control (ctrl),
        .fp_regwrite (rw),
        .fp_dst      (dst),
        .src_a       (sa),
        .src_b       (sb),
        .use_valid   (uv),
        .use_reg     (ur),
        .flush       (fl),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .stall_d     (stall_d),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .wb_regwrite (wb_regwrite),
        .busy        (busy),
        .illegal_op  (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int c);
        case (c)
            0, 1:    return 2;
            2:       return 4;
            3:       return 10;
            4, 5:    return 1;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input bit i_iv, input int i_ctrl, input bit i_rw, input int i_dst,
                         input int i_sa, input int i_sb, input bit i_uv, input int i_ur,
                         input bit i_fl);
        iv   = i_iv;
        ctrl = 4'(i_ctrl);
        rw   = i_rw;
        dst  = 5'(i_dst);
        sa   = 5'(i_sa);
        sb   = 5'(i_sb);
        uv   = i_uv;
        ur   = 5'(i_ur);
        fl   = i_fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        inflight = 0;
        m_op     = 0;
        m_dst    = 0;
        m_rw     = 0;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance it.
    task automatic tick();
        bit legal, ex, dn, raw, acc;
        bit e_start, e_stall, e_wb, e_rwb, e_ill, e_busy;
        @(negedge clk);
        legal = (int'(ctrl) < 6);
        ex    = inflight && (cyc < wb_at);
        dn    = inflight && (cyc == wb_at);
        if (!reset_n) begin
            ex = 0; dn = 0; raw = 0; acc = 0;
            e_start = 0; e_stall = 0; e_ill = 0;
        end else begin
            raw = ex && m_rw &&
                  ((iv && legal && (int'(sa) == m_dst || int'(sb) == m_dst)) ||
                   (uv && int'(ur) == m_dst));
            acc     = iv && !fl && legal && !ex;
            e_start = acc;
            e_stall = !fl && ((iv && legal && ex) || raw);
            e_ill   = iv && !fl && !legal;
        end
        e_wb   = dn;
        e_rwb  = dn && m_rw;
        e_busy = ex || dn;

        chk("fpu_start", 32'(fpu_start), 32'(e_start));
        chk("stall_d", 32'(stall_d), 32'(e_stall));
        chk("wb_valid", 32'(wb_valid), 32'(e_wb));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(e_rwb));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("illegal_op", 32'(illegal_op), 32'(e_ill));
        chk("fpu_op", 32'(fpu_op), 32'(m_op));
        if (dn) chk("wb_dst", 32'(wb_dst), 32'(m_dst));

        got_start = fpu_start;
        got_stall = stall_d;
        got_wb    = wb_valid;
        got_ill   = illegal_op;
        got_busy  = busy;
        got_wbdst = wb_dst;

        if (!reset_n) begin
            model_reset();
        end else begin
            if (dn) inflight = 0;
            if (acc) begin
                inflight = 1;
                wb_at    = cyc + lat_of(int'(ctrl));
                m_op     = int'(ctrl);
                m_dst    = int'(dst);
                m_rw     = rw;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(fpu_start), 32'd0);
        chk({tag, "_stall"}, 32'(stall_d), 32'd0);
        chk({tag, "_wb"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wbrw"}, 32'(wb_regwrite), 32'd0);
        chk({tag, "_wbdst"}, 32'(wb_dst), 32'd0);
        chk({tag, "_op"}, 32'(fpu_op), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ill"}, 32'(illegal_op), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        wb_at = 0;
        model_reset();
        reset_n = 1'b0;
        idle();

        // reset values
        #2;
        chk_reset_vals("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // add f2: start at cycle 0, writeback at cycle 2
        drive(1, 0, 1, 2, 0, 0, 0, 0, 0);
        tick();
        chk("add_start", 32'(got_start), 32'd1);
        idle();
        tick();
        chk("add_busy1", 32'(got_busy), 32'd1);
        tick();
        chk("add_wb", 32'(got_wb), 32'd1);
        chk("add_wbdst", 32'(got_wbdst), 32'd2);
        tick();
        chk("add_idle", 32'(got_busy), 32'd0);

        // div f4, then mul f5 held: 9 stall cycles, mul accepted in div's DONE
        drive(1, 3, 1, 4, 0, 0, 0, 0, 0);
        tick();
        chk("div_start", 32'(got_start), 32'd1);
        drive(1, 2, 1, 5, 1, 3, 0, 0, 0);
        nstall = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (got_stall) nstall++;
            if (k == 10) idle();
        end
        chk("div_stall_cnt", 32'(nstall), 32'd9);
        chk("div_wb_b2b", 32'(got_wb), 32'd1);
        chk("mul_start_b2b", 32'(got_start), 32'd1);
        for (int k = 1; k <= 4; k++) tick();
        chk("mul_wb", 32'(got_wb), 32'd1);
        chk("mul_wbdst", 32'(got_wbdst), 32'd5);

        // mul f7 in EXEC: RAW via use_reg 7 stalls, use_reg 8 does not
        drive(1, 2, 1, 7, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 7, 0);
        tick();
        chk("raw_use_hit", 32'(got_stall), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 1, 8, 0);
        tick();
        chk("raw_use_miss", 32'(got_stall), 32'd0);
        drive(1, 0, 1, 9, 7, 0, 0, 0, 0);
        tick();
        chk("raw_srca_hit", 32'(got_stall), 32'd1);
        tick();
        chk("add_after_mul", 32'(got_start), 32'd1);
        idle();
        for (int k = 0; k < 3; k++) tick();

        // neg then back-to-back abs in neg's DONE cycle
        drive(1, 5, 1, 3, 0, 0, 0, 0, 0);
        tick();
        chk("neg_start", 32'(got_start), 32'd1);
        drive(1, 4, 0, 6, 0, 0, 0, 0, 0);
        tick();
        chk("neg_wb", 32'(got_wb), 32'd1);
        chk("abs_start", 32'(got_start), 32'd1);
        idle();
        tick();
        chk("abs_wb", 32'(got_wb), 32'd1);
        tick();

        // illegal op, then the same op under flush
        drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
        tick();
        chk("ill_pulse", 32'(got_ill), 32'd1);
        chk("ill_nostart", 32'(got_start), 32'd0);
        chk("ill_nostall", 32'(got_stall), 32'd0);
        drive(1, 7, 1, 1, 0, 0, 0, 0, 1);
        tick();
        chk("ill_flush", 32'(got_ill), 32'd0);
        chk("ill_idle", 32'(got_busy), 32'd0);
        idle();
        tick();

        // reset three cycles into a div: outputs clear immediately, no writeback later
        drive(1, 3, 1, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 4, 0, 0, 0, 0, 0);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        tick();
        idle();
        tick();
        reset_n = 1'b1;
        nstall = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (got_wb) nstall++;
        end
        chk("midrst_no_wb", 32'(nstall), 32'd0);

        // random stimulus against the model
        for (int n = 0; n < 2000; n++) begin
            int r;
            int c;
            r = int'($urandom % 10);
            if (r < 8) c = int'($urandom % 6);
            else       c = 6 + int'($urandom % 10);
            drive(($urandom % 10) < 7, c, ($urandom % 4) != 0, int'($urandom % 8),
                  int'($urandom % 8), int'($urandom % 8), ($urandom % 3) == 0,
                  int'($urandom % 8), ($urandom % 10) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
